zip_gen_div: RTL and testbench

//  Parametrised iterative integer divider for the ZipCPU execute stage,

---
 rtl/zip_gen_div.sv | 143 ++++++++++++++
 tb/tb_zip_gen_div.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/zip_gen_div.sv
// Iterative signed/unsigned divider for the ZipCPU execute stage: one
// operation in flight, BW+3 cycles from accepted i_wr to the o_valid strobe.
module zip_gen_div #(
    parameter int BW         = 32,
    parameter int LGBW       = 5,
    parameter bit OPT_SIGNED = 1'b1,
    parameter bit OPT_REM    = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_wr,
    input  logic          i_signed,
    input  logic          i_rem,
    input  logic [BW-1:0] i_numerator,
    input  logic [BW-1:0] i_denominator,
    output logic          o_busy,
    output logic          o_valid,
    output logic          o_err,
    output logic [BW-1:0] o_quotient,
    output logic [3:0]    o_flags,
    output logic [1:0]    o_dbg_state
);

    // Handshake: a request is taken on any rising edge where i_wr=1 and
    // o_busy=0; the result appears as a one-cycle o_valid strobe, never with o_busy.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SIGN   = 2'd1,
        S_DIVIDE = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t          state_q;
    logic [BW-1:0]   num_q;
    logic [BW-1:0]   den_q;
    logic [BW-1:0]   rem_q;
    logic [LGBW-1:0] cnt_q;
    logic            signed_q;
    logic            want_rem_q;
    logic            quo_neg_q;
    logic            rem_neg_q;
    logic            dz_q;
    logic            valid_q;
    logic            err_q;
    logic [BW-1:0]   quot_q;
    logic [3:0]      flags_q;

    logic [BW:0]     trial_d;
    logic            fits_d;
    logic [BW-1:0]   sel_d;
    logic            neg_d;
    logic [BW-1:0]   res_d;
    logic            ovf_d;

    always_comb begin
        trial_d = {rem_q, num_q[BW-1]} - {1'b0, den_q};
        fits_d  = ~trial_d[BW];
        sel_d   = want_rem_q ? rem_q : num_q;
        neg_d   = want_rem_q ? rem_neg_q : quo_neg_q;
        res_d   = neg_d ? (~sel_d + 1'b1) : sel_d;
        // A positive quotient magnitude reaching 2**(BW-1) only happens for MINNEG / -1.
        ovf_d   = signed_q & ~want_rem_q & ~quo_neg_q & num_q[BW-1];
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_IDLE;
            num_q      <= '0;
            den_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            signed_q   <= 1'b0;
            want_rem_q <= 1'b0;
            quo_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            dz_q       <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            quot_q     <= '0;
            flags_q    <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_wr) begin
                        num_q      <= i_numerator;
                        den_q      <= i_denominator;
                        signed_q   <= OPT_SIGNED & i_signed;
                        want_rem_q <= OPT_REM & i_rem;
                        state_q    <= S_SIGN;
                    end
                end
                S_SIGN: begin
                    quo_neg_q <= signed_q & (num_q[BW-1] ^ den_q[BW-1]);
                    rem_neg_q <= signed_q & num_q[BW-1];
                    if (signed_q && num_q[BW-1])
                        num_q <= ~num_q + 1'b1;
                    if (signed_q && den_q[BW-1])
                        den_q <= ~den_q + 1'b1;
                    rem_q <= '0;
                    cnt_q <= LGBW'(BW - 1);
                    if (den_q == '0) begin
                        dz_q    <= 1'b1;
                        state_q <= S_FINISH;
                    end else begin
                        dz_q    <= 1'b0;
                        state_q <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    // num_q shifts the dividend out of its top and the quotient into its bottom.
                    num_q <= {num_q[BW-2:0], fits_d};
                    rem_q <= fits_d ? trial_d[BW-1:0] : {rem_q[BW-2:0], num_q[BW-1]};
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0)
                        state_q <= S_FINISH;
                end
                S_FINISH: begin
                    valid_q <= 1'b1;
                    state_q <= S_IDLE;
                    if (dz_q) begin
                        err_q   <= 1'b1;
                        quot_q  <= '0;
                        flags_q <= '0;
                    end else begin
                        err_q   <= 1'b0;
                        quot_q  <= res_d;
                        flags_q <= {ovf_d, res_d[BW-1], 1'b0, (res_d == '0)};
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_busy      = (state_q != S_IDLE);
    assign o_valid     = valid_q;
    assign o_err       = err_q;
    assign o_quotient  = quot_q;
    assign o_flags     = flags_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_zip_gen_div.sv
// Self-checking bench for zip_gen_div (BW=32): driver pushes model results,
// a negedge monitor pops them on o_valid; latency and busy are checked per op.
module tb_zip_gen_div;

    localparam int BW = 32;
    localparam int W  = 37;  // {err, V, N, C, Z, quotient}

    logic          clk;
    logic          rst_n;
    logic          wr;
    logic          sgn;
    logic          rem;
    logic [BW-1:0] num;
    logic [BW-1:0] den;
    logic          busy;
    logic          valid;
    logic          err;
    logic [BW-1:0] quot;
    logic [3:0]    flags;
    logic [1:0]    dbg_state;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    zip_gen_div #(.BW(BW), .LGBW(5), .OPT_SIGNED(1'b1), .OPT_REM(1'b1)) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_wr         (wr),
        .i_signed     (sgn),
        .i_rem        (rem),
        .i_numerator  (num),
        .i_denominator(den),
        .o_busy       (busy),
        .o_valid      (valid),
        .o_err        (err),
        .o_quotient   (quot),
        .o_flags      (flags),
        .o_dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [31:0] n, input logic [31:0] d,
                                           input bit s, input bit r);
        longint nn, dd, q, rm;
        logic [31:0] res;
        logic v;
        if (d == 32'd0) return {1'b1, 4'b0000, 32'd0};
        if (s) begin
            nn = longint'(signed'(n));
            dd = longint'(signed'(d));
        end else begin
            nn = longint'(n);
            dd = longint'(d);
        end
        q   = nn / dd;
        rm  = nn % dd;
        v   = s && !r && (q > 64'sd2147483647);
        res = r ? rm[31:0] : q[31:0];
        return {1'b0, v, res[31], 1'b0, (res == 32'd0), res};
    endfunction

    // Scoreboard: every o_valid consumes exactly one expected entry.
    always @(negedge clk) begin
        if (valid) begin
            check("busy_with_valid", {63'd0, busy}, 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_valid", {63'd0, valid}, 64'd0);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("result", {27'd0, err, flags, quot}, {27'd0, e});
            end
        end
    end

    // Call right after a negedge; returns right after the negedge of the o_valid cycle.
    task automatic run_op(input logic [31:0] n, input logic [31:0] d, input bit s,
                          input bit r, input int ignore_at);
        int cyc;
        int bad;
        bit got;
        int exp_lat;
        num = n; den = d; sgn = s; rem = r; wr = 1'b1;
        exp_q.push_back(model(n, d, s, r));
        exp_lat = (d == 32'd0) ? 3 : BW + 3;
        @(posedge clk);
        #1 wr = 1'b0;
        cyc = 0; bad = 0; got = 1'b0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (valid) begin
                got = 1'b1;
                wr  = 1'b0;
            end else begin
                if (!busy) bad++;
                if (cyc == ignore_at) begin
                    wr  = 1'b1;
                    num = $urandom;
                    den = 32'($urandom_range(1, 50));
                    sgn = ~s;
                    rem = ~r;
                end else begin
                    wr = 1'b0;
                end
            end
        end
        check("latency", 64'(cyc), 64'(exp_lat));
        check("busy_during_op", 64'(bad), 64'd0);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0; wr = 1'b0; sgn = 1'b0; rem = 1'b0; num = '0; den = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_valid", {63'd0, valid}, 64'd0);
        check("reset_err", {63'd0, err}, 64'd0);
        check("reset_quot", {32'd0, quot}, 64'd0);

        run_op(32'd100, 32'd7, 1'b0, 1'b0, 0);
        run_op(32'd100, 32'd7, 1'b0, 1'b1, 0);
        run_op(32'hFFFF_FF9C, 32'd7, 1'b1, 1'b0, 0);
        run_op(32'hFFFF_FF9C, 32'd7, 1'b1, 1'b1, 0);
        run_op(32'd100, 32'hFFFF_FFF9, 1'b1, 1'b1, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
        run_op(32'h8000_0000, 32'd1, 1'b1, 1'b0, 0);
        run_op(32'h1234_5678, 32'd0, 1'b0, 1'b0, 0);
        run_op(32'h8765_4321, 32'd0, 1'b1, 1'b1, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
        run_op(32'd5, 32'd9, 1'b0, 1'b1, 0);
        run_op(32'd1000, 32'd10, 1'b0, 1'b0, 5);
        run_op(32'hFFFF_F000, 32'd3, 1'b1, 1'b0, 20);

        for (int i = 0; i < 20; i++) begin
            logic [31:0] rn, rd;
            rn = $urandom;
            case ($urandom_range(0, 3))
                0:       rd = 32'($urandom_range(1, 255));
                1:       rd = -32'($urandom_range(1, 255));
                2:       rd = $urandom;
                default: rd = 32'($urandom_range(0, 2));
            endcase
            run_op(rn, rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end

        // Abort an operation with reset in cycle 10; no result may follow.
        num = 32'd500; den = 32'd7; sgn = 1'b0; rem = 1'b0; wr = 1'b1;
        @(posedge clk);
        #1 wr = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_valid", {63'd0, valid}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid || busy) cyc++;
        end
        check("abort_quiet", 64'(cyc), 64'd0);
        run_op(32'd9, 32'd3, 1'b0, 1'b0, 0);

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
